addsub_seq: RTL and testbench

- Multi-cycle wide add/subtract sequencer that feeds the existing 4-bit ripple adder (FA_4) one nibble per clock.
- Accepts WIDTH-bit operands with a start pulse and steps through the slices LSB-first, carrying between them in a register.
- Returns the full-width result with carry and signed-overflow flags.
- Sits directly upstream of FA_4: it drives i_a/i_b/i_c and consumes o_sum/o_carry.

---
 rtl/addsub_pkg.sv | 18 +
 rtl/addsub_seq_fa4.sv | 26 ++
 rtl/addsub_seq.sv | 150 +++++++++++++++
 tb/tb_addsub_seq.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared definitions for the addsub_seq multi-cycle add/subtract sequencer.
// Contents: sequencer state encoding, slice width, and a helper that sizes
// the slice index register from the slice count.
package addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    localparam int SLICE_W = 4;

    function automatic int idx_width(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/addsub_seq_fa4.sv
// FA_4: 4-bit ripple adder used as the per-slice adder of addsub_seq.
// Ports:
//   i_a, i_b  4-bit addends
//   i_c       carry in
//   o_sum     4-bit sum
//   o_carry   carry out
module FA_4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_c,
    output logic [3:0] o_sum,
    output logic       o_carry
);

    logic [4:0] carry_chain;

    always_comb begin
        carry_chain[0] = i_c;
        for (int i = 0; i < 4; i++) begin
            o_sum[i]           = i_a[i] ^ i_b[i] ^ carry_chain[i];
            carry_chain[i + 1] = (i_a[i] & i_b[i]) | (carry_chain[i] & (i_a[i] ^ i_b[i]));
        end
        o_carry = carry_chain[4];
    end

endmodule

// File: rtl/addsub_seq.sv
// addsub_seq: WIDTH-bit add/subtract performed one 4-bit slice per clock
// through a single FA_4, LSB slice first, with the inter-slice carry held
// in a register.
//
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_start          request, only looked at in IDLE
//   i_sub            0 = a+b, 1 = a-b
//   i_a, i_b         operands, latched on an accepted start
//   i_c              carry/borrow in (only with ADDSUB_SEQ_CARRY_IN_EN)
//   o_busy           high while slices are being processed
//   o_done           one-cycle pulse, result and flags valid
//   o_result         sum/difference, held until the next accepted start
//   o_carry          carry out of the top slice (subtract: 1 = no borrow)
//   o_overflow       two's-complement overflow
//
// Build option: define ADDSUB_SEQ_CARRY_IN_EN to add the i_c port for
// chaining multi-word operations.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for i_start; result and flags held
// ST_RUN  | one slice through FA_4 per cycle, LSB first
// ST_DONE | o_done pulse; returns to IDLE on the next edge
module addsub_seq
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_sub,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
`ifdef ADDSUB_SEQ_CARRY_IN_EN
    input  logic             i_c,
`endif
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry,
    output logic             o_overflow
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IDX_W  = idx_width(NSLICE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               cy_q, cy_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carry_q, carry_d;
    logic               ovf_q, ovf_d;

    logic [SLICE_W-1:0] fa_a, fa_b, fa_sum;
    logic               fa_carry;
    logic               cin;

`ifdef ADDSUB_SEQ_CARRY_IN_EN
    // For subtract i_c is a borrow-in, so it enters inverted.
    assign cin = i_sub ? ~i_c : i_c;
`else
    assign cin = i_sub;
`endif

    assign fa_a = a_q[int'(idx_q) * SLICE_W +: SLICE_W];
    assign fa_b = b_q[int'(idx_q) * SLICE_W +: SLICE_W];

    FA_4 u_fa (
        .i_a    (fa_a),
        .i_b    (fa_b),
        .i_c    (cy_q),
        .o_sum  (fa_sum),
        .o_carry(fa_carry)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        cy_d     = cy_q;
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    a_d     = i_a;
                    b_d     = i_sub ? ~i_b : i_b;
                    cy_d    = cin;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                result_d[int'(idx_q) * SLICE_W +: SLICE_W] = fa_sum;
                cy_d  = fa_carry;
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    // fa_sum[3] is the result MSB on the final slice.
                    carry_d = fa_carry;
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (fa_sum[SLICE_W-1] != a_q[WIDTH-1]);
                    idx_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cy_q     <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cy_q     <= cy_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
        end
    end

    assign o_busy     = (state_q == ST_RUN);
    assign o_done     = (state_q == ST_DONE);
    assign o_result   = result_q;
    assign o_carry    = carry_q;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Self-checking bench for addsub_seq (WIDTH=16): directed cases, random
// operations against an arithmetic reference model, ignored restarts,
// reset during RUN, and carry-in chaining when ADDSUB_SEQ_CARRY_IN_EN is set.
module tb_addsub_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin_i;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        carry;
    logic        overflow;

    int tests;
    int fails;

    addsub_seq #(.WIDTH(16)) dut (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_start   (start),
        .i_sub     (sub),
        .i_a       (a),
        .i_b       (b),
`ifdef ADDSUB_SEQ_CARRY_IN_EN
        .i_c       (cin_i),
`endif
        .o_busy    (busy),
        .o_done    (done),
        .o_result  (result),
        .o_carry   (carry),
        .o_overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic. c is carry-in for add, borrow-in for sub.
    task automatic model(input logic [15:0] ma, input logic [15:0] mb, input logic msub,
                         input logic mc, output logic [15:0] r, output logic co, output logic ov);
        int full;
        int sres;
        if (!msub) begin
            full = int'(ma) + int'(mb) + int'(mc);
            sres = int'($signed(ma)) + int'($signed(mb)) + int'(mc);
            co   = (full > 65535);
        end else begin
            full = int'(ma) - int'(mb) - int'(mc);
            sres = int'($signed(ma)) - int'($signed(mb)) - int'(mc);
            co   = (full >= 0);
        end
        r  = full[15:0];
        ov = (sres > 32767) || (sres < -32768);
    endtask

    // Drives one operation and collects what the DUT did; operands are
    // scrambled right after the start edge.
    task automatic do_op(input logic [15:0] oa, input logic [15:0] ob, input logic osub,
                         input logic oc, output logic [15:0] r, output logic co,
                         output logic ov, output int lat, output int nbusy,
                         output logic extra_done, output logic timeout);
        @(negedge clk);
        a = oa; b = ob; sub = osub; cin_i = oc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom); sub = ~osub; cin_i = ~oc;
        lat = 1; nbusy = 0; timeout = 1'b0;
        while (!done && lat < 30) begin
            if (busy) nbusy++;
            @(posedge clk); #1;
            lat++;
        end
        if (!done) timeout = 1'b1;
        r = result; co = carry; ov = overflow;
        @(posedge clk); #1;
        extra_done = done;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; sub = 1'b0; a = 16'hFFFF; b = 16'hFFFF; cin_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({busy, done, result, carry, overflow} !== 20'h0) begin
            fails++;
            $display("FAIL reset_outputs: got busy=%b done=%b result=%h carry=%b ovf=%b, want all 0",
                     busy, done, result, carry, overflow);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_directed();
        logic [15:0] va [5] = '{16'h0003, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
        logic [15:0] vb [5] = '{16'h0004, 16'h0001, 16'h0001, 16'h0009, 16'h0001};
        logic        vs [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [15:0] er [5] = '{16'h0007, 16'h0000, 16'h8000, 16'hFFFC, 16'h7FFF};
        logic        ec [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic        ev [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [15:0] r;
        logic co, ov, xd, to;
        int lat, nb;
        for (int i = 0; i < 5; i++) begin
            do_op(va[i], vb[i], vs[i], 1'b0, r, co, ov, lat, nb, xd, to);
            tests++;
            if (to) begin
                fails++;
                $display("FAIL directed%0d_timeout: no o_done within 30 cycles", i);
            end
            tests++;
            if ({r, co, ov} !== {er[i], ec[i], ev[i]}) begin
                fails++;
                $display("FAIL directed%0d_value: got result=%h carry=%b ovf=%b, want %h %b %b",
                         i, r, co, ov, er[i], ec[i], ev[i]);
            end
            tests++;
            if (lat !== 5 || nb !== 4 || xd !== 1'b0) begin
                fails++;
                $display("FAIL directed%0d_timing: got latency=%0d busy=%0d done_next=%b, want 5 4 0",
                         i, lat, nb, xd);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] ra, rb, r, er;
        logic rs, co, ov, ec, ev, xd, to;
        int lat, nb;
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i % 8 == 0) rb = ra;
            if (i % 8 == 1) ra = 16'h8000;
            rs = 1'($urandom);
            model(ra, rb, rs, 1'b0, er, ec, ev);
            do_op(ra, rb, rs, 1'b0, r, co, ov, lat, nb, xd, to);
            tests++;
            if (to || {r, co, ov} !== {er, ec, ev} || lat !== 5 || xd !== 1'b0) begin
                fails++;
                $display("FAIL random%0d %h%s%h: got result=%h carry=%b ovf=%b lat=%0d to=%b, want %h %b %b lat=5",
                         i, ra, rs ? "-" : "+", rb, r, co, ov, lat, to, er, ec, ev);
            end
        end
    endtask

    task automatic test_back_to_back();
        int ndone;
        logic [15:0] first_res;
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; sub = 1'b0; cin_i = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        a = 16'h4000; b = 16'h0F0F; sub = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        first_res = 16'h0;
        for (int i = 0; i < 14; i++) begin
            if (done) begin
                ndone++;
                if (ndone == 1) first_res = result;
            end
            @(posedge clk); #1;
        end
        tests++;
        if (ndone !== 1) begin
            fails++;
            $display("FAIL restart_ignored_pulses: got %0d o_done pulses, want 1", ndone);
        end
        tests++;
        if (first_res !== 16'h2345) begin
            fails++;
            $display("FAIL restart_ignored_result: got %h, want 2345", first_res);
        end
    endtask

    task automatic test_reset_mid_run();
        int ndone;
        logic [15:0] r, er;
        logic co, ov, ec, ev, xd, to;
        int lat, nb;
        @(negedge clk);
        a = 16'hABCD; b = 16'h1357; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        tests++;
        if ({busy, done, result, carry, overflow} !== 20'h0) begin
            fails++;
            $display("FAIL midrun_reset_outputs: got busy=%b done=%b result=%h carry=%b ovf=%b, want all 0",
                     busy, done, result, carry, overflow);
        end
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        tests++;
        if (ndone !== 0) begin
            fails++;
            $display("FAIL midrun_reset_abandon: got %0d busy/done cycles after reset, want 0", ndone);
        end
        model(16'h0F0F, 16'hF0F1, 1'b0, 1'b0, er, ec, ev);
        do_op(16'h0F0F, 16'hF0F1, 1'b0, 1'b0, r, co, ov, lat, nb, xd, to);
        tests++;
        if (to || {r, co, ov} !== {er, ec, ev}) begin
            fails++;
            $display("FAIL midrun_reset_recover: got result=%h carry=%b ovf=%b to=%b, want %h %b %b",
                     r, co, ov, to, er, ec, ev);
        end
    endtask

`ifdef ADDSUB_SEQ_CARRY_IN_EN
    task automatic test_carry_in();
        logic [15:0] r, er, ra, rb;
        logic co, ov, ec, ev, xd, to, rs, rc;
        int lat, nb;
        do_op(16'h00FF, 16'h0000, 1'b0, 1'b1, r, co, ov, lat, nb, xd, to);
        tests++;
        if (to || r !== 16'h0100) begin
            fails++;
            $display("FAIL carry_in_add: got %h, want 0100", r);
        end
        do_op(16'h0010, 16'h0001, 1'b1, 1'b1, r, co, ov, lat, nb, xd, to);
        tests++;
        if (to || r !== 16'h000E) begin
            fails++;
            $display("FAIL borrow_in_sub: got %h, want 000E", r);
        end
        for (int i = 0; i < 16; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            rs = 1'($urandom); rc = 1'($urandom);
            model(ra, rb, rs, rc, er, ec, ev);
            do_op(ra, rb, rs, rc, r, co, ov, lat, nb, xd, to);
            tests++;
            if (to || {r, co, ov} !== {er, ec, ev}) begin
                fails++;
                $display("FAIL carry_in_random%0d: got %h %b %b, want %h %b %b", i, r, co, ov, er, ec, ev);
            end
        end
    endtask
`endif

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
`ifdef ADDSUB_SEQ_CARRY_IN_EN
        test_carry_in();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
